// File: rtl/nvram_ioctl_reader.sv
// nvram_ioctl_reader: serves HPS upload read strobes from the battery-backed NVRAM
module nvram_ioctl_reader #(
  parameter int ADDR_W = 8,
  parameter int NV_SIZE = 256,
  parameter int RD_LATENCY = 1,
  parameter logic [7:0] UPLOAD_INDEX = 8'd4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] nv_addr,
  output logic              nv_rd,
  input  logic [7:0]        nv_q,
  output logic              cpu_hold,
  output logic [15:0]       bytes_read,
  output logic              done
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, PRESENT = 2'd3;
  logic [1:0] state, lat_cnt;
  logic active, act_q;
  assign active = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  // wait is raised in the strobe cycle itself so hps_io never samples stale data
  always_comb ioctl_wait = (state == IDLE && ioctl_rd && active) || state == ISSUE || state == WAIT;
  // session tracking on the registered active edge plus the read FSM; an upload end overrides any read in flight
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      lat_cnt <= '0;
      act_q <= 1'b0;
      ioctl_din <= 8'h00;
      nv_addr <= '0;
      nv_rd <= 1'b0;
      cpu_hold <= 1'b0;
      bytes_read <= 16'd0;
      done <= 1'b0;
    end else begin
      act_q <= active;
      nv_rd <= 1'b0;
      done <= 1'b0;
      if (!active && act_q) begin
        cpu_hold <= 1'b0;
        done <= 1'b1;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (ioctl_rd && active) begin
            if (ioctl_addr < 25'(NV_SIZE)) begin
              state <= ISSUE;
              nv_rd <= 1'b1;
              nv_addr <= ioctl_addr[ADDR_W-1:0];
            end else begin
              state <= PRESENT;
              ioctl_din <= 8'hFF;
            end
          end
          ISSUE: begin
            lat_cnt <= 2'(RD_LATENCY - 1);
            state <= WAIT;
          end
          WAIT: if (lat_cnt == 2'd0) begin
            ioctl_din <= nv_q;
            state <= PRESENT;
          end else lat_cnt <= lat_cnt - 2'd1;
          default: begin
            if (bytes_read != 16'hFFFF) bytes_read <= bytes_read + 16'd1;
            state <= IDLE;
          end
        endcase
      end
      if (active && !act_q) begin
        cpu_hold <= 1'b1;
        bytes_read <= 16'd0;
      end
    end
  end
endmodule

// File: tb/tb_nvram_ioctl_reader.sv
// tb_nvram_ioctl_reader: scoreboard bench for the NVRAM upload reader at latency 1 and 3
module tb_nvram_ioctl_reader;
  logic clk_sys = 1'b0, reset = 1'b1, ioctl_upload = 1'b0, ioctl_rd = 1'b0, sel = 1'b0;
  logic [7:0] ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] din1, din3, nva1, nva3, q1, q3, din, nva;
  logic w1, w3, r1, r3, h1, h3, d1, d3, wt, nrd, hold, dn;
  logic [15:0] b1, b3, bytes;
  logic [7:0] mem [256];
  logic [7:0] p1 [3];
  logic [7:0] p3 [3];
  logic [7:0] sb [$];
  int checks = 0, errors = 0;

  always #10 clk_sys = ~clk_sys;

  nvram_ioctl_reader #(.RD_LATENCY(1)) u_dut1 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din1), .ioctl_wait(w1),
    .nv_addr(nva1), .nv_rd(r1), .nv_q(q1), .cpu_hold(h1), .bytes_read(b1), .done(d1));

  nvram_ioctl_reader #(.RD_LATENCY(3)) u_dut3 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din3), .ioctl_wait(w3),
    .nv_addr(nva3), .nv_rd(r3), .nv_q(q3), .cpu_hold(h3), .bytes_read(b3), .done(d3));

  // NVRAM models: data only appears for an issued read, after the configured latency
  always @(posedge clk_sys) begin
    p1[0] <= r1 ? mem[nva1] : 8'h5A;
    p1[1] <= p1[0];
    p1[2] <= p1[1];
    p3[0] <= r3 ? mem[nva3] : 8'h5A;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign q1 = p1[0];
  assign q3 = p3[2];

  assign din = sel ? din3 : din1;
  assign wt = sel ? w3 : w1;
  assign nrd = sel ? r3 : r1;
  assign nva = sel ? nva3 : nva1;
  assign hold = sel ? h3 : h1;
  assign dn = sel ? d3 : d1;
  assign bytes = sel ? b3 : b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_din"}, 32'(din), 32'h00);
    check({tag, "_wait"}, 32'(wt), 32'd0);
    check({tag, "_nv_addr"}, 32'(nva), 32'd0);
    check({tag, "_nv_rd"}, 32'(nrd), 32'd0);
    check({tag, "_hold"}, 32'(hold), 32'd0);
    check({tag, "_bytes"}, 32'(bytes), 32'd0);
    check({tag, "_done"}, 32'(dn), 32'd0);
  endtask

  // one strobe; lat_exp counts cycles from the strobe to the first cycle with wait low
  task automatic rd(input logic [24:0] a, input int lat_exp);
    int n, rds;
    n = 0;
    rds = 0;
    sb.push_back(a < 25'd256 ? mem[a[7:0]] : 8'hFF);
    ioctl_addr = a;
    ioctl_rd = 1'b1;
    @(negedge clk_sys);
    check("wait_strobe", 32'(wt), 32'd1);
    tick();
    ioctl_rd = 1'b0;
    while (n < 20) begin
      @(negedge clk_sys);
      n++;
      if (nrd) begin
        rds++;
        check("nv_addr", 32'(nva), 32'(a[7:0]));
      end
      if (!wt) break;
    end
    check("latency", 32'(n), 32'(lat_exp));
    check("nv_rd_count", 32'(rds), 32'(a < 25'd256));
    check("din", 32'(din), 32'(sb.pop_front()));
    tick();
  endtask

  initial begin
    int rds, ws;
    logic [15:0] b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (2) tick();
    @(negedge clk_sys);
    reset_vals("reset");
    tick();
    reset = 1'b0;
    // wrong index: strobes are not ours
    ioctl_index = 8'd0;
    ioctl_upload = 1'b1;
    repeat (2) tick();
    ioctl_addr = 25'd5;
    ioctl_rd = 1'b1;
    rds = 0;
    ws = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      rds += int'(nrd);
      ws += int'(wt);
      tick();
      ioctl_rd = 1'b0;
    end
    check("idx0_wait", 32'(ws), 32'd0);
    check("idx0_nv_rd", 32'(rds), 32'd0);
    check("idx0_bytes", 32'(bytes), 32'd0);
    check("idx0_hold", 32'(hold), 32'd0);
    // basic read of a marked byte
    ioctl_upload = 1'b0;
    tick();
    ioctl_index = 8'd4;
    ioctl_upload = 1'b1;
    mem[16] = 8'hA5;
    repeat (2) tick();
    check("hold_start", 32'(hold), 32'd1);
    rd(25'h10, 3);
    check("bytes_one", 32'(bytes), 32'd1);
    mem[16] = 8'h10;
    // full ramp in a fresh session
    ioctl_upload = 1'b0;
    tick();
    ioctl_upload = 1'b1;
    repeat (2) tick();
    check("bytes_cleared", 32'(bytes), 32'd0);
    for (int a = 0; a < 256; a++) begin
      rd(25'(a), 3);
      check("hold_ramp", 32'(hold), 32'd1);
    end
    check("bytes_256", 32'(bytes), 32'd256);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("done_before", 32'(dn), 32'd0);
    @(negedge clk_sys);
    check("done_pulse", 32'(dn), 32'd1);
    check("hold_drop", 32'(hold), 32'd0);
    @(negedge clk_sys);
    check("done_end", 32'(dn), 32'd0);
    tick();
    // out of range, including high bits that must not alias
    ioctl_upload = 1'b1;
    repeat (2) tick();
    rd(25'h100, 1);
    rd(25'h10010, 1);
    check("bytes_oor", 32'(bytes), 32'd2);
    // second strobe during a read is ignored
    b0 = bytes;
    ioctl_addr = 25'h20;
    ioctl_rd = 1'b1;
    sb.push_back(mem[8'h20]);
    tick();
    ioctl_addr = 25'h30;
    rds = 0;
    @(negedge clk_sys);
    rds += int'(nrd);
    check("dbl_nv_addr", 32'(nva), 32'h20);
    tick();
    ioctl_rd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      rds += int'(nrd);
      if (!wt) break;
    end
    check("dbl_din", 32'(din), 32'(sb.pop_front()));
    repeat (4) begin
      tick();
      rds += int'(nrd);
    end
    check("dbl_nv_rd", 32'(rds), 32'd1);
    check("dbl_bytes", 32'(bytes), 32'(b0 + 16'd1));
    // abort mid-read
    rd(25'h40, 3);
    b0 = bytes;
    sb.push_back(mem[8'h40]);
    ioctl_addr = 25'h50;
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    ioctl_upload = 1'b0;
    tick();
    @(negedge clk_sys);
    check("abort_wait", 32'(wt), 32'd0);
    check("abort_din", 32'(din), 32'(sb.pop_front()));
    check("abort_done", 32'(dn), 32'd1);
    tick();
    check("abort_bytes", 32'(bytes), 32'(b0));
    // reset mid-read
    ioctl_upload = 1'b1;
    repeat (2) tick();
    ioctl_addr = 25'h60;
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk_sys);
    reset_vals("midrst");
    tick();
    reset = 1'b0;
    // latency-3 build
    sel = 1'b1;
    mem[8'h33] = 8'hC3;
    repeat (3) tick();
    rd(25'h33, 5);
    check("lat3_bytes", 32'(bytes), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
